// File: rtl/ram_hex_viewer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ram_hex_viewer: steps a pointer through a synchronous-read memory and shows |
// | each fetched word on active-low 7-segment digits.        Revision 1.0       |
// +-----------------------------------------------------------------------------+
module ram_hex_viewer #(
   parameter int DATA_WIDTH      = 16,
   parameter int ADDR_WIDTH      = 8,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int AUTO_PERIOD     = 25000000,
   parameter int BLANK_LZ        = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          step_btn,
   input  logic                          dir,
   input  logic                          auto_en,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   input  logic [DATA_WIDTH-1:0]         mem_rdata,
   output logic                          busy,
   output logic [7*(DATA_WIDTH/4)-1:0]   seg
);
   localparam int DIGITS = DATA_WIDTH / 4;
   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int AUTO_W = $clog2(AUTO_PERIOD);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2
   } state_t;

   logic                  sync_q1;
   logic                  sync_q2;
   logic                  db_level;
   logic [DB_W-1:0]       db_cnt;
   logic                  btn_evt;
   logic [AUTO_W-1:0]     auto_cnt;
   logic                  auto_evt;
   logic                  step_evt;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr, addr_nxt;
   logic [DATA_WIDTH-1:0] disp_reg, disp_nxt;
   logic                  pending, pending_nxt;

   // Debounced level only moves after an unbroken run of mismatching samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q1  <= 1'b0;
         sync_q2  <= 1'b0;
         db_level <= 1'b0;
         db_cnt   <= '0;
         btn_evt  <= 1'b0;
      end else begin
         sync_q1 <= step_btn;
         sync_q2 <= sync_q1;
         btn_evt <= 1'b0;
         if (sync_q2 != db_level) begin
            if (db_cnt == DB_LAST) begin
               db_level <= sync_q2;
               db_cnt   <= '0;
               btn_evt  <= sync_q2;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   assign auto_evt = auto_en && (auto_cnt == AUTO_LAST);
   assign step_evt = btn_evt | auto_evt;

   always_ff @(posedge clk) begin
      if (reset || !auto_en) begin
         auto_cnt <= '0;
      end else if (auto_evt) begin
         auto_cnt <= '0;
      end else begin
         auto_cnt <= auto_cnt + 1'b1;
      end
   end

   // Reset lands in FETCH so address 0 is loaded without a user step.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= FETCH;
         addr     <= '0;
         disp_reg <= '0;
         pending  <= 1'b0;
      end else begin
         state    <= state_nxt;
         addr     <= addr_nxt;
         disp_reg <= disp_nxt;
         pending  <= pending_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      addr_nxt    = addr;
      disp_nxt    = disp_reg;
      pending_nxt = pending;
      case (state)
         IDLE: begin
            if (step_evt || pending) begin
               addr_nxt    = dir ? addr + 1'b1 : addr - 1'b1;
               pending_nxt = 1'b0;
               state_nxt   = FETCH;
            end
         end
         FETCH: begin
            if (step_evt) pending_nxt = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (step_evt) pending_nxt = 1'b1;
            disp_nxt  = mem_rdata;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign mem_addr = addr;
   assign busy     = (state != IDLE);

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // A digit blanks when it and every more-significant nibble are zero.
   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      logic blank;
      if (BLANK_LZ != 0 && k > 0) begin : g_blank
         assign blank = (disp_reg[DATA_WIDTH-1:4*k] == '0);
      end else begin : g_noblank
         assign blank = 1'b0;
      end
      assign seg[7*k +: 7] = blank ? 7'b1111111 : hex7(disp_reg[4*k +: 4]);
   end

endmodule
`default_nettype wire

// File: tb/tb_ram_hex_viewer.sv
`default_nettype none
// tb_ram_hex_viewer: directed checks of stepping, debounce, wrap, pending, blanking and reset.
module tb_ram_hex_viewer;
   localparam logic [27:0] SEG_ZERO   = {7'h40, 7'h40, 7'h40, 7'h40};
   localparam logic [27:0] SEG_A000   = {7'h08, 7'h40, 7'h40, 7'h40};
   localparam logic [27:0] SEG_A001   = {7'h08, 7'h40, 7'h40, 7'h79};
   localparam logic [27:0] SEG_A002   = {7'h08, 7'h40, 7'h40, 7'h24};
   localparam logic [27:0] SEG_A0FF   = {7'h08, 7'h40, 7'h0E, 7'h0E};
   localparam logic [27:0] SEG_B_ZERO = {7'h7F, 7'h7F, 7'h7F, 7'h40};
   localparam logic [27:0] SEG_B_0040 = {7'h7F, 7'h7F, 7'h19, 7'h40};

   logic        clk = 1'b0;
   logic        reset;
   logic        step_btn, dir, auto_en;
   logic        btn_b, auto_b;
   logic        dir_b = 1'b1;
   logic [7:0]  mem_addr_a, mem_addr_b;
   logic [15:0] rdata_a, rdata_b;
   logic        busy_a, busy_b;
   logic [27:0] seg_a, seg_b;
   logic [15:0] mem_a [256];
   logic [15:0] mem_b [256];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      rdata_a <= mem_a[mem_addr_a];
      rdata_b <= mem_b[mem_addr_b];
   end

   ram_hex_viewer #(
      .DATA_WIDTH(16), .ADDR_WIDTH(8), .DEBOUNCE_CYCLES(4), .AUTO_PERIOD(8), .BLANK_LZ(0)
   ) dut_a (
      .clk(clk), .reset(reset), .step_btn(step_btn), .dir(dir), .auto_en(auto_en),
      .mem_addr(mem_addr_a), .mem_rdata(rdata_a), .busy(busy_a), .seg(seg_a)
   );

   ram_hex_viewer #(
      .DATA_WIDTH(16), .ADDR_WIDTH(8), .DEBOUNCE_CYCLES(2), .AUTO_PERIOD(4), .BLANK_LZ(1)
   ) dut_b (
      .clk(clk), .reset(reset), .step_btn(btn_b), .dir(dir_b), .auto_en(auto_b),
      .mem_addr(mem_addr_b), .mem_rdata(rdata_b), .busy(busy_b), .seg(seg_b)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press_a(input logic d);
      dir      = d;
      step_btn = 1'b1;
      repeat (10) tick();
      step_btn = 1'b0;
      repeat (12) tick();
   endtask

   initial begin
      reset = 1'b1; step_btn = 1'b0; dir = 1'b1; auto_en = 1'b0;
      btn_b = 1'b0; auto_b = 1'b0;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 16'hA000 + 16'(i);
         mem_b[i] = 16'hA000 + 16'(i);
      end
      mem_b[3] = 16'h0040;
      mem_b[4] = 16'h0000;

      // Reset state
      repeat (3) tick();
      check("rst_addr", 32'(mem_addr_a), 32'h0);
      check("rst_busy", 32'(busy_a), 32'h1);
      check("rst_seg", 32'(seg_a), 32'(SEG_ZERO));
      check("rst_seg_blank", 32'(seg_b), 32'(SEG_B_ZERO));
      reset = 1'b0;
      tick();
      check("init_busy1", 32'(busy_a), 32'h1);
      check("init_seg1", 32'(seg_a), 32'(SEG_ZERO));
      tick();
      check("init_busy2", 32'(busy_a), 32'h0);
      check("init_seg2", 32'(seg_a), 32'(SEG_A000));
      check("init_seg_b", 32'(seg_b), 32'(SEG_A000));

      // Bouncing button yields one step
      dir = 1'b1;
      step_btn = 1'b1; repeat (2) tick();
      step_btn = 1'b0; repeat (2) tick();
      step_btn = 1'b1; repeat (2) tick();
      step_btn = 1'b0; repeat (2) tick();
      step_btn = 1'b1; repeat (10) tick();
      step_btn = 1'b0; repeat (12) tick();
      check("bounce_addr", 32'(mem_addr_a), 32'h1);
      check("bounce_seg", 32'(seg_a), 32'(SEG_A001));

      // Down to 0, wrap to FF, wrap back up to 0
      press_a(1'b0);
      check("down_addr", 32'(mem_addr_a), 32'h0);
      press_a(1'b0);
      check("wrapdn_addr", 32'(mem_addr_a), 32'hFF);
      check("wrapdn_seg", 32'(seg_a), 32'(SEG_A0FF));
      press_a(1'b1);
      check("wrapup_addr", 32'(mem_addr_a), 32'h0);
      check("wrapup_seg", 32'(seg_a), 32'(SEG_A000));

      // Auto step at E8, button event lands in FETCH at E9
      tick();
      auto_en = 1'b1;
      repeat (2) tick();
      step_btn = 1'b1;
      repeat (6) tick();
      check("pend_addr1", 32'(mem_addr_a), 32'h1);
      check("pend_busy_f", 32'(busy_a), 32'h1);
      auto_en = 1'b0;
      tick();
      check("pend_busy_w", 32'(busy_a), 32'h1);
      tick();
      check("pend_idle_gap", 32'(busy_a), 32'h0);
      check("pend_seg1", 32'(seg_a), 32'(SEG_A001));
      tick();
      check("pend_addr2", 32'(mem_addr_a), 32'h2);
      check("pend_busy2", 32'(busy_a), 32'h1);
      repeat (2) tick();
      check("pend_seg2", 32'(seg_a), 32'(SEG_A002));
      check("pend_busy3", 32'(busy_a), 32'h0);
      step_btn = 1'b0;
      repeat (12) tick();
      check("pend_settle", 32'(mem_addr_a), 32'h2);

      // Reset in WAIT with a pending step outstanding
      tick();
      auto_en = 1'b1;
      repeat (2) tick();
      step_btn = 1'b1;
      repeat (4) tick();
      step_btn = 1'b0;
      repeat (2) tick();
      check("mid_addr3", 32'(mem_addr_a), 32'h3);
      auto_en = 1'b0;
      tick();
      check("mid_wait_busy", 32'(busy_a), 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_seg", 32'(seg_a), 32'(SEG_ZERO));
      check("mid_rst_addr", 32'(mem_addr_a), 32'h0);
      check("mid_rst_busy", 32'(busy_a), 32'h1);
      repeat (2) tick();
      check("mid_refetch_seg", 32'(seg_a), 32'(SEG_A000));
      check("mid_refetch_busy", 32'(busy_a), 32'h0);
      repeat (10) tick();
      check("mid_no_pending", 32'(mem_addr_a), 32'h0);

      // Four events on dut_b: auto E4, btn E5, auto E8, btn E9 (dropped)
      tick();
      auto_b = 1'b1; btn_b = 1'b1;
      repeat (2) tick();
      btn_b = 1'b0;
      repeat (2) tick();
      check("drop_addr1", 32'(mem_addr_b), 32'h1);
      check("drop_busy1", 32'(busy_b), 32'h1);
      btn_b = 1'b1;
      repeat (2) tick();
      check("drop_idle_gap", 32'(busy_b), 32'h0);
      check("drop_seg1", 32'(seg_b), 32'(SEG_A001));
      btn_b = 1'b0;
      tick();
      check("drop_addr2", 32'(mem_addr_b), 32'h2);
      tick();
      auto_b = 1'b0;
      repeat (2) tick();
      check("drop_addr3", 32'(mem_addr_b), 32'h3);
      repeat (10) tick();
      check("drop_settle", 32'(mem_addr_b), 32'h3);
      check("blank_0040", 32'(seg_b), 32'(SEG_B_0040));

      btn_b = 1'b1;
      repeat (6) tick();
      btn_b = 1'b0;
      repeat (8) tick();
      check("blank_addr4", 32'(mem_addr_b), 32'h4);
      check("blank_0000", 32'(seg_b), 32'(SEG_B_ZERO));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
